fetch_queue_unit: RTL and testbench
===================================

// Module: fetch_queue_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the next-generation pipelined core.
//  Owns the PC and issues requests to a multi-cycle, in-order instruction memory
//  (req/gnt, then rvalid). Buffers returned instructions in a FQ_DEPTH-entry queue
//  and hands them to decode over a valid/ready handshake.
//  Handles branch redirects by flushing the queue and dropping in-flight responses,
//  and stops fetching after a HLT instruction.
// PARAMETERS
//  DATA_W     16     instruction width
//  ADDR_W     16     instruction address width
//  PC_INC     2      address increment per instruction
//  FQ_DEPTH   4      queue entries (power of 2, >=2)
//  MAX_OUT    2      maximum outstanding memory requests (1..FQ_DEPTH)
//  RESET_PC   0      fetch address after reset
//  HLT_OP     4'hF   opcode (instr[DATA_W-1 -: 4]) that halts fetch
// PORTS
//  clk           in   1        clock, all state on rising edge
//  rst_n         in   1        asynchronous active-low reset
//  imem_req      out  1        fetch request
//  imem_addr     out  ADDR_W   request address; held stable while req && !gnt
//  imem_gnt      in   1        request accepted this cycle
//  imem_rvalid   in   1        response valid (in request order, >=1 cycle after gnt)
//  imem_rdata    in   DATA_W   response instruction
//  redirect      in   1        branch taken: flush and refetch from redirect_pc
//  redirect_pc   in   ADDR_W   new fetch address
//  if_valid      out  1        queue head valid
//  if_instr      out  DATA_W   queue head instruction
//  if_pc         out  ADDR_W   queue head address + PC_INC
//  id_ready      in   1        decode accepts head this cycle
//  pc            out  ADDR_W   next fetch address
//  halted        out  1        HLT fetched; no further requests
// BEHAVIOUR
//  Reset: pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0, state RUN.
//   All outputs are 0 except pc.
//  issue = imem_req & imem_gnt. On each issue, pc += PC_INC (modulo 2^ADDR_W) and
//   outstanding increments. On each rvalid, outstanding decrements.
//  imem_req = RUN & !redirect & (count+outstanding < FQ_DEPTH) & (outstanding < MAX_OUT).
//   An ungranted req may drop only on redirect or halt.
//   Invariant: count + outstanding <= FQ_DEPTH.
//  Response handling: if drop_cnt>0 or state HALTED, the response is discarded and
//   drop_cnt decrements (saturating at 0). Otherwise {rdata, resp_pc+PC_INC} is pushed
//   and resp_pc += PC_INC.
//  Queue: registered FIFO. A push is visible on if_valid the next cycle.
//   Pop = if_valid & id_ready. Push and pop in the same cycle are both honoured.
//   Overflow is impossible by credit rule.
//  Latency: gnt at cycle t, rvalid at t+1 (earliest), if_valid at t+2.
//  Redirect (highest priority):
//   - Queue flushed.
//   - pc and resp_pc <= redirect_pc.
//   - drop_cnt <= outstanding + issue - rvalid; the same-cycle rvalid is discarded.
//   - No request that cycle.
//   - state <= RUN.
//   - A same-cycle pop counts as consumed by decode.
//  State RUN->HALTED: when a pushed instruction has opcode HLT_OP.
//   - The HLT itself is queued and delivered.
//   - halted=1 from the next cycle.
//   - req deasserts; remaining responses are discarded.
//  HALTED->RUN: only on redirect.
//  HLT and redirect in the same cycle: redirect wins; the HLT is flushed.
//  Async reset mid-operation: immediate clear; the memory is reset by the same rst_n.
// TESTING
//  1 reset, gnt=1, 1-cycle memory, id_ready=1 -> imem_addr 0,2,4..; if_pc 2,4,6..;
//    if_valid from cycle 2.
//  2 id_ready=0, 3-cycle latency -> at most 2 outstanding; req stops at count=4;
//    count+outstanding<=4 every cycle.
//  3 redirect to 0x0040 with 2 outstanding -> both responses dropped; next
//    if_instr from 0x0040, if_pc=0x0042.
//  4 0xF000 at 0x0006 -> delivered with if_pc=0x0008; halted=1; req=0; later
//    rvalid ignored; redirect to 0x0000 resumes fetch.
//  5 redirect + pop + rvalid in one cycle -> queue empty next cycle;
//    drop_cnt = outstanding-1; pc=redirect_pc.
//  6 rst_n low mid-burst with full queue -> if_valid=0, pc=RESET_PC immediately;
//    normal fetch after release.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the PC, issues credit-limited requests to an in-order
// instruction memory, queues responses for decode, and handles redirect flushes and HLT.
module fetch_queue_unit #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                PC_INC   = 2,
    parameter int                FQ_DEPTH = 4,
    parameter int                MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HLT_OP   = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam int CNT_W = $clog2(FQ_DEPTH + 1);
    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam logic [CNT_W:0]    DEPTH_LIM = (CNT_W + 1)'(FQ_DEPTH);
    localparam logic [CNT_W-1:0]  OUT_LIM   = CNT_W'(MAX_OUT);
    localparam logic [ADDR_W-1:0] INC       = ADDR_W'(PC_INC);

    typedef enum logic {RUN, HALTED} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] resp_pc;
    logic [CNT_W-1:0]  count, outstanding, drop_cnt, out_next;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [DATA_W-1:0] q_instr [FQ_DEPTH];
    logic [ADDR_W-1:0] q_pc    [FQ_DEPTH];
    logic [CNT_W:0]    credit_used;
    logic              issue, discard, push, pop, hlt_seen;

    // Every queue slot is reserved at request time, so a response can never overflow the queue.
    assign credit_used = {1'b0, count} + {1'b0, outstanding};
    assign imem_req    = rst_n && (state == RUN) && !redirect &&
                         (credit_used < DEPTH_LIM) && (outstanding < OUT_LIM);
    assign imem_addr   = pc;
    assign issue       = imem_req && imem_gnt;
    assign discard     = imem_rvalid && (redirect || (drop_cnt != '0) || (state == HALTED));
    assign push        = imem_rvalid && !discard;
    assign pop         = if_valid && id_ready;
    assign hlt_seen    = push && (imem_rdata[DATA_W-1 -: 4] == HLT_OP);
    assign out_next    = outstanding + CNT_W'(issue) - CNT_W'(imem_rvalid);

    assign if_valid = (count != '0);
    assign if_instr = if_valid ? q_instr[rd_ptr] : '0;
    assign if_pc    = if_valid ? q_pc[rd_ptr] : '0;
    assign halted   = (state == HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    // Redirect outranks a same-cycle HLT, which is flushed along with the rest of the queue.
    always_comb begin
        state_next = state;
        if (redirect)      state_next = RUN;
        else if (hlt_seen) state_next = HALTED;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect) begin
                pc       <= redirect_pc;
                resp_pc  <= redirect_pc;
                drop_cnt <= out_next;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (issue) pc <= pc + INC;
                if (discard && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
                if (push) begin
                    resp_pc <= resp_pc + INC;
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Queue storage needs no reset: if_valid gates the head fields.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= resp_pc + INC;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: an in-order memory model with fixed latency feeds
// the DUT, and hand-derived values are checked at chosen cycles.
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        id_ready = 1'b0;
    logic [15:0] pc;
    logic        halted;

    int          assert_count = 0;
    int          fail_count = 0;
    int          cyc;
    int          latency;
    bit          gnt_en;
    bit          hlt_en;
    logic [15:0] hlt_addr;
    logic [15:0] pend_addr[$];
    int          pend_due[$];
    bit          issued;
    logic [15:0] issued_addr;
    int          issue_total;
    int          deliver_total;

    fetch_queue_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
        .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_data(input logic [15:0] a);
        return (hlt_en && a == hlt_addr) ? 16'hF000 : {4'h1, a[11:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // One clock cycle: memory drives responses at negedge, grants are recorded, then the edge.
    task automatic applyStimulus();
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
            deliver_total++;
        end
        imem_gnt = gnt_en;
        #1;
        issued = imem_req && imem_gnt;
        if (issued) begin
            issued_addr = imem_addr;
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + latency);
            issue_total++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        pend_addr.delete(); pend_due.delete();
        cyc = 0; issue_total = 0; deliver_total = 0; hlt_en = 1'b0; hlt_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", if_valid, 0);
        checkOutput("rst_pc", pc, 0);
        checkOutput("rst_req", imem_req, 0);
        checkOutput("rst_halted", halted, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Streaming fetch with a 1-cycle memory.
        doReset();
        latency = 1; gnt_en = 1'b1; id_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            applyStimulus();
            checkOutput("t1_issue", issued, 1);
            checkOutput("t1_addr", issued_addr, 2 * k);
            if (k == 0) begin
                checkOutput("t1_valid_first", if_valid, 0);
            end else begin
                checkOutput("t1_valid", if_valid, 1);
                checkOutput("t1_if_pc", if_pc, 2 * k);
                checkOutput("t1_instr", if_instr, 16'h1000 + 2 * (k - 1));
            end
        end
        checkOutput("t1_next_pc", pc, 12);

        // Decode stalled, 3-cycle memory: credit limits.
        doReset();
        latency = 3; gnt_en = 1'b1; id_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus();
            checkOutput("t2_max_out", pend_addr.size() <= 2, 1);
            checkOutput("t2_credit", (deliver_total + pend_addr.size()) <= 4, 1);
        end
        checkOutput("t2_issues", issue_total, 4);
        checkOutput("t2_pc", pc, 8);
        checkOutput("t2_full_req", imem_req, 0);
        checkOutput("t2_head_pc", if_pc, 2);
        checkOutput("t2_head_instr", if_instr, 16'h1000);
        id_ready = 1'b1;
        applyStimulus();
        checkOutput("t2_no_issue_full", issued, 0);
        checkOutput("t2_pop1_pc", if_pc, 4);
        applyStimulus();
        checkOutput("t2_refill_addr", issued_addr, 8);
        checkOutput("t2_pop2_pc", if_pc, 6);

        // Redirect with two requests in flight.
        doReset();
        latency = 3; gnt_en = 1'b1; id_ready = 1'b1;
        repeat (2) applyStimulus();
        checkOutput("t3_inflight", pend_addr.size(), 2);
        redirect = 1'b1; redirect_pc = 16'h0040;
        applyStimulus();
        redirect = 1'b0;
        checkOutput("t3_redir_noreq", issued, 0);
        checkOutput("t3_redir_pc", pc, 16'h0040);
        for (int k = 0; k < 4; k++) begin
            applyStimulus();
            checkOutput("t3_dropped", if_valid, 0);
        end
        applyStimulus();
        checkOutput("t3_valid", if_valid, 1);
        checkOutput("t3_instr", if_instr, 16'h1040);
        checkOutput("t3_if_pc", if_pc, 16'h0042);

        // HLT at 0x0006 stops fetch until a redirect.
        doReset();
        latency = 1; gnt_en = 1'b1; id_ready = 1'b1;
        hlt_en = 1'b1; hlt_addr = 16'h0006;
        repeat (4) applyStimulus();
        checkOutput("t4_not_halted", halted, 0);
        applyStimulus();
        checkOutput("t4_hlt_instr", if_instr, 16'hF000);
        checkOutput("t4_hlt_pc", if_pc, 16'h0008);
        checkOutput("t4_halted", halted, 1);
        applyStimulus();
        checkOutput("t4_halt_noissue", issued, 0);
        checkOutput("t4_resp_ignored", if_valid, 0);
        checkOutput("t4_halt_pc", pc, 16'h000A);
        repeat (2) applyStimulus();
        checkOutput("t4_still_idle", if_valid, 0);
        checkOutput("t4_req_low", imem_req, 0);
        redirect = 1'b1; redirect_pc = 16'h0000;
        applyStimulus();
        redirect = 1'b0;
        checkOutput("t4_resumed", halted, 0);
        checkOutput("t4_resume_pc", pc, 0);
        applyStimulus();
        checkOutput("t4_resume_addr", issued_addr, 0);
        applyStimulus();
        checkOutput("t4_resume_instr", if_instr, 16'h1000);
        checkOutput("t4_resume_if_pc", if_pc, 2);

        // Redirect, pop and rvalid in the same cycle.
        doReset();
        latency = 3; gnt_en = 1'b1; id_ready = 1'b0;
        repeat (7) applyStimulus();
        checkOutput("t5_pre_valid", if_valid, 1);
        checkOutput("t5_pre_inflight", pend_addr.size(), 2);
        redirect = 1'b1; redirect_pc = 16'h0080; id_ready = 1'b1;
        applyStimulus();
        redirect = 1'b0;
        checkOutput("t5_flushed", if_valid, 0);
        checkOutput("t5_pc", pc, 16'h0080);
        applyStimulus();
        checkOutput("t5_one_dropped", if_valid, 0);
        checkOutput("t5_new_addr", issued_addr, 16'h0080);
        repeat (2) applyStimulus();
        checkOutput("t5_wait", if_valid, 0);
        applyStimulus();
        checkOutput("t5_valid", if_valid, 1);
        checkOutput("t5_instr", if_instr, 16'h1080);
        checkOutput("t5_if_pc", if_pc, 16'h0082);

        // Asynchronous reset with a full queue.
        doReset();
        latency = 3; gnt_en = 1'b1; id_ready = 1'b0;
        repeat (12) applyStimulus();
        checkOutput("t6_full_valid", if_valid, 1);
        checkOutput("t6_pc_before", pc, 8);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_async_valid", if_valid, 0);
        checkOutput("t6_async_pc", pc, 0);
        checkOutput("t6_async_req", imem_req, 0);
        doReset();
        latency = 1; gnt_en = 1'b1; id_ready = 1'b1;
        applyStimulus();
        checkOutput("t6_first_addr", issued_addr, 0);
        applyStimulus();
        checkOutput("t6_valid", if_valid, 1);
        checkOutput("t6_instr", if_instr, 16'h1000);
        checkOutput("t6_if_pc", if_pc, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
